// File: rtl/ext_tx_pkg.sv
// Shared widths, hold-state encoding and beat payload type for the external TX buffer.
package ext_tx_pkg;

    localparam int unsigned BEAT_W      = 64;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BEAT_STRB_W = BEAT_W / 8;
    localparam int unsigned WORD_STRB_W = WORD_W / 8;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_LO    = 1'b1
    } hold_state_e;

    typedef struct packed {
        logic [BEAT_W-1:0]      dat;
        logic [BEAT_STRB_W-1:0] strb;
    } beat_t;

endpackage

// File: rtl/ext_tx_fifo.sv
// Generic data+strobe FIFO with combinational head read; push ignored when full, pop ignored when empty.
module ext_tx_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STRB_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic [STRB_W-1:0]          strb_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic [STRB_W-1:0]          strb_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [STRB_W-1:0] strb_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == CNT_W'(0));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign data_o  = data_q[rptr_q];
    assign strb_o  = strb_q[rptr_q];
    assign count_o = count_q;

    // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                strb_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                data_q[wptr_q] <= data_i;
                strb_q[wptr_q] <= strb_i;
                wptr_q         <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ext_tx_buffer.sv
// Packs 32-bit TCDM words into 64-bit beats and queues them for the TX data port.
// Optional: define EXT_TX_BUF_FALLTHROUGH_EN to present a beat pushed into an empty FIFO in the same cycle.
module ext_tx_buffer
    import ext_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WORD_W-1:0]        in_data_i,
    input  logic [WORD_STRB_W-1:0]   in_strb_i,
    input  logic                     in_lane_i,
    input  logic                     in_last_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [BEAT_W-1:0]        tx_data_dat_o,
    output logic [BEAT_STRB_W-1:0]   tx_data_strb_o,
    output logic                     tx_data_gnt_o,
    input  logic                     tx_data_req_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    hold_state_e              state_q, state_d;
    logic [WORD_W-1:0]        hold_lo_q, hold_lo_d;
    logic [WORD_STRB_W-1:0]   hold_strb_q, hold_strb_d;
    logic                     push;
    beat_t                    push_beat;
    logic                     fifo_push;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [BEAT_W-1:0]        fifo_dat;
    logic [BEAT_STRB_W-1:0]   fifo_strb;

    // A low-lane word while a low half is held must first flush the held half.
    assign in_ready_o = !fifo_full && !((state_q == HOLD_LO) && !in_lane_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HOLD_EMPTY;
            hold_lo_q   <= '0;
            hold_strb_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_lo_q   <= hold_lo_d;
            hold_strb_q <= hold_strb_d;
        end
    end

    // Packing decisions: capture low half, emit half/full beats, or flush the held half.
    always_comb begin
        state_d     = state_q;
        hold_lo_d   = hold_lo_q;
        hold_strb_d = hold_strb_q;
        push        = 1'b0;
        push_beat   = '0;
        case (state_q)
            HOLD_EMPTY: begin
                if (in_valid_i && !fifo_full) begin
                    if (in_lane_i) begin
                        push           = 1'b1;
                        push_beat.dat  = {in_data_i, WORD_W'(0)};
                        push_beat.strb = {in_strb_i, WORD_STRB_W'(0)};
                    end else if (in_last_i) begin
                        push           = 1'b1;
                        push_beat.dat  = {WORD_W'(0), in_data_i};
                        push_beat.strb = {WORD_STRB_W'(0), in_strb_i};
                    end else begin
                        hold_lo_d   = in_data_i;
                        hold_strb_d = in_strb_i;
                        state_d     = HOLD_LO;
                    end
                end
            end
            HOLD_LO: begin
                if (in_valid_i && !fifo_full) begin
                    push    = 1'b1;
                    state_d = HOLD_EMPTY;
                    if (in_lane_i) begin
                        push_beat.dat  = {in_data_i, hold_lo_q};
                        push_beat.strb = {in_strb_i, hold_strb_q};
                    end else begin
                        push_beat.dat  = {WORD_W'(0), hold_lo_q};
                        push_beat.strb = {WORD_STRB_W'(0), hold_strb_q};
                    end
                end
            end
            default: state_d = HOLD_EMPTY;
        endcase
    end

`ifdef EXT_TX_BUF_FALLTHROUGH_EN
    logic bypass;

    // A beat entering an empty FIFO is shown directly; if it is consumed at once it never lands.
    assign bypass         = push && fifo_empty;
    assign fifo_push      = push && !(bypass && tx_data_req_i);
    assign tx_data_gnt_o  = !fifo_empty || push;
    assign tx_data_dat_o  = fifo_empty ? push_beat.dat  : fifo_dat;
    assign tx_data_strb_o = fifo_empty ? push_beat.strb : fifo_strb;
`else
    assign fifo_push      = push;
    assign tx_data_gnt_o  = !fifo_empty;
    assign tx_data_dat_o  = fifo_dat;
    assign tx_data_strb_o = fifo_strb;
`endif

    ext_tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (BEAT_W),
        .STRB_W (BEAT_STRB_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (push_beat.dat),
        .strb_i  (push_beat.strb),
        .pop_i   (tx_data_req_i),
        .data_o  (fifo_dat),
        .strb_o  (fifo_strb),
        .count_o (count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_ext_tx_buffer.sv
// Directed self-checking bench for ext_tx_buffer (DEPTH=4); fall-through checks follow EXT_TX_BUF_FALLTHROUGH_EN.
module tb_ext_tx_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_strb;
    logic        in_lane;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dat;
    logic [7:0]  strb;
    logic        gnt;
    logic        req;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_tx_buffer #(.DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_data_i      (in_data),
        .in_strb_i      (in_strb),
        .in_lane_i      (in_lane),
        .in_last_i      (in_last),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .tx_data_dat_o  (dat),
        .tx_data_strb_o (strb),
        .tx_data_gnt_o  (gnt),
        .tx_data_req_i  (req),
        .count_o        (count)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_lane  = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        in_strb  = '0;
        req      = 1'b0;
    endtask

    task automatic offer(input logic lane, input logic last, input logic [31:0] d, input logic [3:0] s);
        in_valid = 1'b1;
        in_lane  = lane;
        in_last  = last;
        in_data  = d;
        in_strb  = s;
    endtask

    task automatic pop_one();
        req = 1'b1;
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
        checks++; if (dat !== 64'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", dat); end
        checks++; if (strb !== 8'h0) begin errors++; $display("FAIL reset_strb: got %h expected 0", strb); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pack();
        offer(1'b0, 1'b0, 32'h11111111, 4'hF);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pack_ready_lo: got %b expected 1", in_ready); end
        tick();
        offer(1'b1, 1'b0, 32'h22222222, 4'h3);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pack_ready_hi: got %b expected 1", in_ready); end
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL pack_count: got %0d expected 1", count); end
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL pack_gnt: got %b expected 1", gnt); end
        checks++; if (dat !== 64'h22222222_11111111) begin errors++; $display("FAIL pack_dat: got %h expected 2222222211111111", dat); end
        checks++; if (strb !== 8'h3F) begin errors++; $display("FAIL pack_strb: got %h expected 3f", strb); end
        pop_one();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL pack_pop_count: got %0d expected 0", count); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL pack_pop_gnt: got %b expected 0", gnt); end
    endtask

    task automatic test_last_lane0();
        offer(1'b0, 1'b1, 32'hAAAA5555, 4'hC);
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL last_count: got %0d expected 1", count); end
        checks++; if (dat !== 64'h00000000_AAAA5555) begin errors++; $display("FAIL last_dat: got %h expected 00000000aaaa5555", dat); end
        checks++; if (strb !== 8'h0C) begin errors++; $display("FAIL last_strb: got %h expected 0c", strb); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL last_no_hold: got %b expected 1", in_ready); end
        pop_one();
    endtask

    task automatic test_flush();
        offer(1'b0, 1'b0, 32'h12345678, 4'hF);
        tick();
        offer(1'b0, 1'b0, 32'hBEEF0000, 4'hF);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low: got %b expected 0", in_ready); end
        tick();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_back: got %b expected 1", in_ready); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", count); end
        tick();
        idle();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_new_hold: got %b expected 0", in_ready); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_count2: got %0d expected 1", count); end
        checks++; if (dat !== 64'h00000000_12345678) begin errors++; $display("FAIL flush_dat: got %h expected 0000000012345678", dat); end
        checks++; if (strb !== 8'h0F) begin errors++; $display("FAIL flush_strb: got %h expected 0f", strb); end
        offer(1'b1, 1'b0, 32'h0000CAFE, 4'h3);
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush_count3: got %0d expected 2", count); end
        pop_one();
        checks++; if (dat !== 64'h0000CAFE_BEEF0000) begin errors++; $display("FAIL flush_pair_dat: got %h expected 0000cafebeef0000", dat); end
        checks++; if (strb !== 8'h3F) begin errors++; $display("FAIL flush_pair_strb: got %h expected 3f", strb); end
        pop_one();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_drain: got %0d expected 0", count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 1'b1, 32'hC0DE0000 + 32'(i), 4'hF);
            tick();
        end
        idle();
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", in_ready); end
        checks++; if (dat !== 64'hC0DE0000_00000000) begin errors++; $display("FAIL full_head: got %h expected c0de000000000000", dat); end
        checks++; if (strb !== 8'hF0) begin errors++; $display("FAIL full_strb: got %h expected f0", strb); end
        offer(1'b1, 1'b0, 32'hC0DE0004, 4'hF);
        req = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pushpop_ready: got %b expected 0", in_ready); end
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pushpop_count: got %0d expected 3", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b expected 1", in_ready); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (dat !== {32'hC0DE0000 + 32'(i), 32'h0}) begin
                errors++; $display("FAIL full_drain_dat%0d: got %h expected %h", i, dat, {32'hC0DE0000 + 32'(i), 32'h0});
            end
            pop_one();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", count); end
    endtask

    task automatic test_req_empty();
        req = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL req_empty_count: got %0d expected 0", count); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL req_empty_gnt: got %b expected 0", gnt); end
    endtask

    task automatic test_reset_mid();
        offer(1'b1, 1'b0, 32'h11, 4'hF);
        tick();
        offer(1'b1, 1'b0, 32'h22, 4'hF);
        tick();
        offer(1'b0, 1'b0, 32'h33, 4'hF);
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL mid_count: got %0d expected 2", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_hold: got %b expected 0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt: got %b expected 0", gnt); end
        checks++; if (dat !== 64'h0) begin errors++; $display("FAIL mid_rst_dat: got %h expected 0", dat); end
        checks++; if (strb !== 8'h0) begin errors++; $display("FAIL mid_rst_strb: got %h expected 0", strb); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_hold_gone: got %b expected 1", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_after_count: got %0d expected 0", count); end
    endtask

    task automatic test_latency();
        offer(1'b1, 1'b0, 32'h5A5A5A5A, 4'hF);
        #1;
`ifdef EXT_TX_BUF_FALLTHROUGH_EN
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL lat_same_gnt: got %b expected 1", gnt); end
        checks++; if (dat !== 64'h5A5A5A5A_00000000) begin errors++; $display("FAIL lat_same_dat: got %h expected 5a5a5a5a00000000", dat); end
`else
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL lat_same_gnt: got %b expected 0", gnt); end
`endif
        tick();
        idle();
        #1;
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL lat_next_gnt: got %b expected 1", gnt); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL lat_next_count: got %0d expected 1", count); end
        pop_one();
        offer(1'b1, 1'b0, 32'h77777777, 4'hF);
        req = 1'b1;
        #1;
`ifdef EXT_TX_BUF_FALLTHROUGH_EN
        checks++; if (strb !== 8'hF0) begin errors++; $display("FAIL lat_bypass_strb: got %h expected f0", strb); end
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL lat_bypass_count: got %0d expected 0", count); end
`else
        tick();
        idle();
        #1;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL lat_req_ignored: got %0d expected 1", count); end
        pop_one();
`endif
    endtask

    initial begin
        test_reset();
        test_pack();
        test_last_lane0();
        test_flush();
        test_full();
        test_req_empty();
        test_reset_mid();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_tx_buffer.md
EXT_TX_BUFFER -- requirements
Module: ext_tx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO capacity in 64-bit beats; power of two, at least 2.
REQ-002 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data_i  input  32  write word from TCDM side.
REQ-005 SHALL have port in_strb_i  input  4  byte enables of in_data_i.
REQ-006 SHALL have port in_lane_i  input  1  target half of the beat: 0 = bits 31:0, 1 = bits 63:32.
REQ-007 SHALL have port in_last_i  input  1  final word of the transfer.
REQ-008 SHALL have port in_valid_i  input  1  word offered.
REQ-009 SHALL have port in_ready_o  output  1  word accepted when in_valid_i and in_ready_o are both high.
REQ-010 SHALL have port tx_data_dat_o  output  64  head beat data.
REQ-011 SHALL have port tx_data_strb_o  output  8  head beat strobes.
REQ-012 SHALL have port tx_data_gnt_o  output  1  head beat available.
REQ-013 SHALL have port tx_data_req_i  input  1  pop request; a pop happens when tx_data_req_i and tx_data_gnt_o are both high.
REQ-014 SHALL have port count_o  output  clog2(DEPTH)+1  number of FIFO entries.

Function
REQ-015 SHALL pack words into beats through a hold register with states HOLD_EMPTY and HOLD_LO.
REQ-016 SHALL, in HOLD_EMPTY, on accept with lane 0 and last 0: store word and strobe in the low half, then go to HOLD_LO.
REQ-017 SHALL, in HOLD_EMPTY, on accept with lane 0 and last 1: push {32'h0, word} with strobe {4'h0, strb}, and stay in HOLD_EMPTY.
REQ-018 SHALL, in HOLD_EMPTY, on accept with lane 1: push {word, 32'h0} with strobe {strb, 4'h0}, ignore in_last_i, and stay in HOLD_EMPTY.
REQ-019 SHALL, in HOLD_LO, on accept with lane 1: push {word, hold_lo} with strobe {strb, hold_strb}, then go to HOLD_EMPTY.
REQ-020 SHALL, in HOLD_LO with in_valid_i=1 and in_lane_i=0: drive in_ready_o=0; if the FIFO is not full, push the hold beat alone ({32'h0, hold_lo}, strobe {4'h0, hold_strb}) and go to HOLD_EMPTY (flush; the word is accepted on a later cycle).
REQ-021 SHALL drive in_ready_o = (count_o < DEPTH) && !(HOLD_LO && in_lane_i==0); a same-cycle pop does not free space for a push.
REQ-022 SHALL drive tx_data_gnt_o = (count_o != 0); dat/strb SHALL be the entry at the read pointer (combinational read).
REQ-023 SHALL give one cycle of latency from the push edge to the beat being visible at the output.
REQ-024 SHALL ignore tx_data_req_i while tx_data_gnt_o=0: no pointer or count change.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-026 SHALL wrap pointers modulo DEPTH and never push when count_o equals DEPTH.

Reset
REQ-027 SHALL, while rst_ni=0, drive state HOLD_EMPTY, hold register 0, pointers 0, count_o 0, FIFO storage 0, tx_data_gnt_o 0, tx_data_dat_o 0, tx_data_strb_o 0, and in_ready_o 1.
REQ-028 SHALL discard any partial hold word and all queued beats when reset asserts mid-transfer.

Configuration
REQ-029 SHALL, with EXT_TX_BUF_FALLTHROUGH_EN defined, make a beat pushed into an empty FIFO visible in the same cycle (tx_data_gnt_o=1, dat/strb driven from the push path).
REQ-030 SHALL, in fall-through mode, not write the FIFO and leave count unchanged when that beat is also popped in the same cycle.
REQ-031 SHALL, without EXT_TX_BUF_FALLTHROUGH_EN, keep the behaviour of REQ-023.

Structure
REQ-032 SHALL take the hold-state enum, the beat width (64), the word width (32) and the strobe widths from package ext_tx_pkg.
REQ-033 SHALL implement storage in the sub-module ext_tx_fifo (generic data+strobe FIFO with push/pop/count); packing logic stays in ext_tx_buffer.

Verification
REQ-034 SHALL check: lane0 0x11111111 strb 0xF, then lane1 0x22222222 strb 0x3 -> one beat 0x22222222_11111111, strb 0x3F, count_o 1.
REQ-035 SHALL check: lane0 0xAAAA5555 strb 0xC with last=1 -> beat 0x00000000_AAAA5555, strb 0x0C, no HOLD_LO.
REQ-036 SHALL check: HOLD_LO then lane0 word 0xBEEF0000 -> in_ready_o=0 for one cycle, flush beat strb 0x0F, then 0xBEEF0000 is held as a new low half.
REQ-037 SHALL check: DEPTH=4, four lane1 pushes with no pops -> count_o 4, in_ready_o 0; then one pop -> in_ready_o 1 on the next cycle.
REQ-038 SHALL check: full FIFO with push and pop offered in the same cycle -> pop only, count_o 3.
REQ-039 SHALL check: assert rst_ni mid-transfer with count_o 2 and HOLD_LO -> all outputs at their REQ-027 values; run with and without EXT_TX_BUF_FALLTHROUGH_EN and check push-to-gnt latency of 0 and 1 cycles respectively.
